// File: rtl/pl_bram_rd_pkg.sv
// Shared definitions for the PL BRAM read engine: register map, bit positions,
// AXI response codes and the read FSM state encoding.
package pl_bram_rd_pkg;

  localparam int REG_CTRL     = 0;
  localparam int REG_STATUS   = 1;
  localparam int REG_BASE     = 2;
  localparam int REG_LEN      = 3;
  localparam int REG_CSUM     = 4;
  localparam int REG_LAST     = 5;
  localparam int REG_SCRATCH0 = 6;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_CLR_DONE_BIT = 1;
  localparam int STATUS_BUSY_BIT   = 0;
  localparam int STATUS_DONE_BIT   = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/pl_bram_rd_engine_if.sv
// AXI4-Lite slave bundle for the BRAM read engine; master side belongs to the
// PS interconnect (or a testbench), slave side to the engine register file.
interface pl_bram_rd_engine_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/pl_bram_rd_axil_regs.sv
// AXI4-Lite handshake and register file for the BRAM read engine. CTRL bits
// leave as single-cycle pulses; STATUS/CSUM/LAST are supplied by the engine.
module pl_bram_rd_axil_regs
  import pl_bram_rd_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 6,
  parameter int NUM_REGS = 8
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  pl_bram_rd_engine_if.slave  s_axi,
  input  logic                busy_i,
  input  logic [DW-1:0]       status_i,
  input  logic [DW-1:0]       csum_i,
  input  logic [DW-1:0]       last_i,
  output logic                start_o,
  output logic                clr_done_o,
  output logic [DW-1:0]       base_o,
  output logic [DW-1:0]       len_o
);

  localparam int ADDR_LSB = $clog2(DW/8);
  localparam int WIW      = AW - ADDR_LSB;
  localparam int NUM_SCR  = (NUM_REGS > REG_SCRATCH0) ? NUM_REGS - REG_SCRATCH0 : 1;

  logic          awready_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          arready_q;
  logic          rvalid_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] base_q;
  logic [DW-1:0] len_q;
  logic [DW-1:0] scratch_q [NUM_SCR];

  logic          wr_hs;
  logic          rd_hs;
  logic [WIW-1:0] wr_idx;
  logic [WIW-1:0] rd_idx;
  logic          wr_ok;
  logic          rd_ok;
  logic [DW-1:0] rd_mux;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0]   old_v,
                                               input logic [DW-1:0]   new_v,
                                               input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < DW/8; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign wr_idx = s_axi.S_AXI_AWADDR[AW-1:ADDR_LSB];
  assign rd_idx = s_axi.S_AXI_ARADDR[AW-1:ADDR_LSB];
  assign wr_ok  = 32'(wr_idx) < NUM_REGS;
  assign rd_ok  = 32'(rd_idx) < NUM_REGS;
  assign wr_hs  = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_hs  = arready_q & s_axi.S_AXI_ARVALID;

  // CTRL is write-only with self-clearing bits, so it is never stored.
  assign start_o    = wr_hs & (32'(wr_idx) == REG_CTRL) &
                      s_axi.S_AXI_WSTRB[0] & s_axi.S_AXI_WDATA[CTRL_START_BIT];
  assign clr_done_o = wr_hs & (32'(wr_idx) == REG_CTRL) &
                      s_axi.S_AXI_WSTRB[0] & s_axi.S_AXI_WDATA[CTRL_CLR_DONE_BIT];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      base_q    <= '0;
      len_q     <= '0;
      for (int i = 0; i < NUM_SCR; i++) scratch_q[i] <= '0;
    end else begin
      awready_q <= s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q & ~awready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (wr_hs && wr_ok) begin
        if (!busy_i && 32'(wr_idx) == REG_BASE)
          base_q <= apply_strb(base_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
        if (!busy_i && 32'(wr_idx) == REG_LEN)
          len_q <= apply_strb(len_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
        for (int i = 0; i < NUM_SCR; i++) begin
          if (NUM_REGS > REG_SCRATCH0 && 32'(wr_idx) == REG_SCRATCH0 + i)
            scratch_q[i] <= apply_strb(scratch_q[i], s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (32'(rd_idx) == REG_STATUS) rd_mux = status_i;
    if (32'(rd_idx) == REG_BASE)   rd_mux = base_q;
    if (32'(rd_idx) == REG_LEN)    rd_mux = len_q;
    if (32'(rd_idx) == REG_CSUM)   rd_mux = csum_i;
    if (32'(rd_idx) == REG_LAST)   rd_mux = last_i;
    for (int i = 0; i < NUM_SCR; i++) begin
      if (NUM_REGS > REG_SCRATCH0 && 32'(rd_idx) == REG_SCRATCH0 + i) rd_mux = scratch_q[i];
    end
  end

  // Read data is captured at the handshake edge, so a STATUS read racing a
  // DONE update returns the value from before the update.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      arready_q <= s_axi.S_AXI_ARVALID & ~rvalid_q & ~arready_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        rdata_q  <= rd_ok ? rd_mux : '0;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign base_o = base_q;
  assign len_o  = len_q;

  logic unused_axi;
  assign unused_axi = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: rtl/pl_bram_rd_engine.sv
// AXI4-Lite controlled BRAM read engine: streams LEN words from BASE at one word
// per cycle, accumulating a modular checksum and the last word returned.
//
// state    | meaning
// ST_IDLE  | waiting for START; DONE holds the result of the previous run
// ST_ISSUE | bram_en high, one address per cycle, captures overlap issue
// ST_DRAIN | all reads issued; waiting for the last RD_LAT returns, then DONE
module pl_bram_rd_engine
  import pl_bram_rd_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 8,
  parameter int BRAM_ADDR_WIDTH    = 10,
  parameter int RD_LAT             = 1
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  pl_bram_rd_engine_if.slave            s_axi,
  output logic [BRAM_ADDR_WIDTH-1:0]    bram_addr,
  output logic                          bram_en,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] bram_dout,
  output logic                          irq_done
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int BAW = BRAM_ADDR_WIDTH;

  rd_state_e       state_q;
  logic [DW-1:0]   issue_left_q;
  logic [DW-1:0]   cap_left_q;
  logic [DW-1:0]   csum_q;
  logic [DW-1:0]   last_q;
  logic [RD_LAT-1:0] vld_q;
  logic            done_q;
  logic            bram_en_q;
  logic [BAW-1:0]  bram_addr_q;

  logic            start;
  logic            clr_done;
  logic [DW-1:0]   base;
  logic [DW-1:0]   len;
  logic [DW-1:0]   status_d;
  logic            busy;
  logic            capture;

  assign busy    = (state_q != ST_IDLE);
  assign capture = vld_q[RD_LAT-1];

  always_comb begin
    status_d = '0;
    status_d[STATUS_BUSY_BIT] = busy;
    status_d[STATUS_DONE_BIT] = done_q;
  end

  pl_bram_rd_axil_regs #(
    .DW       (DW),
    .AW       (C_S_AXI_ADDR_WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_regs (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .s_axi      (s_axi),
    .busy_i     (busy),
    .status_i   (status_d),
    .csum_i     (csum_q),
    .last_i     (last_q),
    .start_o    (start),
    .clr_done_o (clr_done),
    .base_o     (base),
    .len_o      (len)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= ST_IDLE;
      issue_left_q <= '0;
      cap_left_q   <= '0;
      csum_q       <= '0;
      last_q       <= '0;
      vld_q        <= '0;
      done_q       <= 1'b0;
      bram_en_q    <= 1'b0;
      bram_addr_q  <= '0;
    end else begin
      // vld_q tracks which issued reads are still in the BRAM pipeline
      vld_q[0] <= bram_en_q;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];

      if (capture) begin
        csum_q     <= csum_q + bram_dout;
        last_q     <= bram_dout;
        cap_left_q <= cap_left_q - 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            done_q     <= 1'b0;
            csum_q     <= '0;
            cap_left_q <= len;
            if (len == '0) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q      <= ST_ISSUE;
              bram_en_q    <= 1'b1;
              bram_addr_q  <= base[BAW-1:0];
              issue_left_q <= len - 1'b1;
            end
          end else if (clr_done) begin
            done_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (issue_left_q == '0) begin
            bram_en_q <= 1'b0;
            state_q   <= ST_DRAIN;
          end else begin
            issue_left_q <= issue_left_q - 1'b1;
            bram_addr_q  <= bram_addr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cap_left_q == '0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bram_en   = bram_en_q;
  assign bram_addr = bram_addr_q;
  assign irq_done  = done_q;

  logic unused_base;
  assign unused_base = ^base[DW-1:BAW];

endmodule
